if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage that produces the IF_PC / IF_Instruction pair consumed by the IF/ID pipeline register, and generates that register's ID_Flush.
- Owns the program counter and handles stalls from the ID-stage hazard unit.
- Redirects the PC on branch, jump or exception, and inserts a one-cycle bubble after each redirect.
- Runs a request/ready handshake to instruction memory, with a one-entry hold buffer so no fetched word is lost during a stall.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset (supervisor bit set).
XADR, 32'h8000_0008, exception/interrupt vector.

Ports:
clk  input  1  clock, rising-edge
reset  input  1  synchronous, active-high reset
ID_Stall  input  1  hazard stall; IF outputs must hold
Exception  input  1  redirect to XADR (highest priority)
Branch_Taken  input  1  redirect to Branch_Target
Branch_Target  input  32  branch destination
Jump_Taken  input  1  redirect to Jump_Target
Jump_Target  input  32  jump destination
Imem_Req  output  1  fetch request
Imem_Addr  output  32  fetch address (= pc)
Imem_Ready  input  1  Imem_Data valid this cycle for Imem_Addr
Imem_Data  input  32  fetched word
IF_PC  output  32  fetched address + 4 (link value)
IF_Instruction  output  32  fetched word, 0 when invalid
IF_Valid  output  1  IF_PC/IF_Instruction carry a real instruction
ID_Flush  output  1  one-cycle flush pulse to the IF/ID register

Behaviour:
- Reset (synchronous, priority over all inputs):
  - pc=RESET_PC, state=FETCH, hold_valid=0.
  - IF_PC=0, IF_Instruction=0, IF_Valid=0, ID_Flush=0.
- PC increment rule: pc_next = {pc[31], pc[30:0]+4}. Bit 31 is never changed by increment, so 0x7FFFFFFC -> 0x00000000 and 0xFFFFFFFC -> 0x80000000.
- Redirect target rules:
  - Exception: target = XADR.
  - Branch/jump: new pc = {pc[31] & target[31], target[30:0]}. User mode cannot enter supervisor space.
- Redirect priority: Exception > Branch_Taken > Jump_Taken > sequential. A redirect overrides ID_Stall.
- Imem_Addr = pc at all times.
- Imem_Req = 1 only in FETCH; it is 0 in HOLD, REDIRECT and during reset.
- Handshake: a fetch completes in any cycle with Imem_Req && Imem_Ready. Memory may hold Imem_Ready low for any number of cycles; pc and Imem_Addr stay stable while it does.
- FSM states:
  - FETCH:
    - Redirect: pc<=target, hold_valid<=0, IF_Valid<=0, IF_Instruction<=0; go to REDIRECT.
    - Else, fetch completes and !ID_Stall: outputs <= {pc+4, Imem_Data}, IF_Valid<=1, pc<=pc_next.
    - Else, fetch completes and ID_Stall: hold buffer <= {pc+4, Imem_Data}, hold_valid<=1, pc<=pc_next; go to HOLD. Outputs unchanged.
    - Else, no fetch and !ID_Stall: IF_Valid<=0 (bubble). No fetch and ID_Stall: outputs hold.
  - HOLD:
    - Redirect: discard the buffer, same actions as FETCH redirect; go to REDIRECT.
    - Else ID_Stall: everything holds.
    - Else !ID_Stall: outputs <= hold buffer, IF_Valid<=1, hold_valid<=0; go to FETCH.
  - REDIRECT (exactly one cycle):
    - ID_Flush=1, IF_Valid=0, Imem_Req=0; return to FETCH.
    - A further redirect arriving in this cycle is accepted: pc is updated, state stays REDIRECT for one more cycle.
- ID_Flush is registered and equals (state==REDIRECT). It is never asserted in any other state.
- Reset asserted mid-stall or mid-wait discards the buffer and any pending fetch; the first request after reset release uses RESET_PC.
- Latency: an instruction accepted at edge N is visible on IF_* after edge N. From a redirect at edge N, the first new instruction appears no earlier than edge N+2.

Decomposition:
- Shared package cpu_pkg:
  - Constants RESET_PC, XADR, PC_INC=4, SUPERVISOR_BIT=31.
  - FSM state enum {FETCH, HOLD, REDIRECT}.
- One natural sub-module, if_pc_next: combinational redirect-priority and supervisor-bit masking logic. Kept separate so it can be unit-tested on its own.

Test Plan:
1. Reset held 2 cycles, then released with Imem_Ready=1 and memory returning addr^32'hA5A5A5A5 -> Imem_Addr 0x80000000, 0x80000004, ...; IF_PC 0x80000004, 0x80000008, ...; IF_Valid=1 from the first fetch.
2. ID_Stall high for 3 cycles after a fetch at pc=0x80000010 -> one word captured in HOLD; Imem_Req=0; IF_* unchanged. On release, IF_PC=0x80000014, then fetch resumes at 0x80000018 with no word lost or duplicated.
3. pc=0x00000100 (user mode), Branch_Taken with Branch_Target=0x80000200 -> next Imem_Addr=0x00000200; ID_Flush pulses exactly 1 cycle; IF_Valid=0 that cycle.
4. Exception, Branch_Taken and Jump_Taken asserted together at pc=0x00000040 -> pc=0x80000008 (XADR); branch and jump ignored.
5. Imem_Ready low 4 cycles at pc=0x80000020, with a jump to 0x80000100 arriving in cycle 2 -> stalled fetch abandoned; after REDIRECT, Imem_Addr=0x80000100.
6. pc=0x7FFFFFFC with sequential fetch -> next pc=0x00000000; bit 31 stays 0. Then assert reset during a HOLD state -> hold_valid=0, IF_Valid=0, pc=0x80000000.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and fetch FSM state encoding for the IF stage.
//   RESET_PC / XADR  : default reset PC and exception vector
//   PC_INC           : sequential fetch stride in bytes
//   SUPERVISOR_BIT   : PC bit that marks supervisor address space
//   fetch_state_t    : FETCH / HOLD / REDIRECT
package cpu_pkg;

    localparam logic [31:0] RESET_PC       = 32'h8000_0000;
    localparam logic [31:0] XADR           = 32'h8000_0008;
    localparam logic [31:0] PC_INC         = 32'd4;
    localparam int          SUPERVISOR_BIT = 31;

    typedef enum logic [1:0] {FETCH, HOLD, REDIRECT} fetch_state_t;

endpackage

// File: rtl/if_pc_next.sv
// if_pc_next: combinational next-PC selection for the fetch unit.
//   pc                          : current program counter
//   Exception/Branch_*/Jump_*   : redirect requests and targets
//   redirect                    : any redirect requested this cycle
//   redirect_pc                 : prioritised, supervisor-masked redirect target
//   seq_pc                      : sequential successor of pc
module if_pc_next #(
    parameter logic [31:0] XADR = cpu_pkg::XADR
) (
    input  logic [31:0] pc,
    input  logic        Exception,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic        Jump_Taken,
    input  logic [31:0] Jump_Target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] seq_pc
);
    import cpu_pkg::*;

    logic [31:0] sel_tgt;

    assign sel_tgt = Branch_Taken ? Branch_Target : Jump_Target;
    assign redirect = Exception | Branch_Taken | Jump_Taken;
    // A branch/jump may only keep the supervisor bit if already in supervisor space.
    assign redirect_pc = Exception ? XADR
                       : {pc[SUPERVISOR_BIT] & sel_tgt[SUPERVISOR_BIT], sel_tgt[30:0]};
    // Increment never carries into the supervisor bit.
    assign seq_pc = {pc[SUPERVISOR_BIT], pc[30:0] + PC_INC[30:0]};

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID register.
//   clk, reset                       : clock, synchronous active-high reset
//   ID_Stall                         : hazard stall, IF outputs hold
//   Exception/Branch_*/Jump_*        : PC redirect requests (Exception highest)
//   Imem_Req/Imem_Addr               : fetch request and address (= pc)
//   Imem_Ready/Imem_Data             : fetch completion and returned word
//   IF_PC/IF_Instruction/IF_Valid    : fetched address + 4, word, valid
//   ID_Flush                         : one-cycle flush pulse after a redirect
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [31:0] XADR     = cpu_pkg::XADR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_Stall,
    input  logic        Exception,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    input  logic        Jump_Taken,
    input  logic [31:0] Jump_Target,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Ready,
    input  logic [31:0] Imem_Data,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_Instruction,
    output logic        IF_Valid,
    output logic        ID_Flush
);
    import cpu_pkg::*;

    fetch_state_t state;
    logic [31:0]  pc, hold_pc, hold_instr, redirect_pc, seq_pc;
    logic         hold_valid, redirect, fetch;

    if_pc_next #(.XADR(XADR)) u_pc_next (
        .pc            (pc),
        .Exception     (Exception),
        .Branch_Taken  (Branch_Taken),
        .Branch_Target (Branch_Target),
        .Jump_Taken    (Jump_Taken),
        .Jump_Target   (Jump_Target),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .seq_pc        (seq_pc)
    );

    assign Imem_Addr = pc;
    assign Imem_Req  = (state == FETCH) && !reset;
    assign fetch     = Imem_Req && Imem_Ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            state          <= FETCH;
            hold_valid     <= 1'b0;
            hold_pc        <= '0;
            hold_instr     <= '0;
            IF_PC          <= '0;
            IF_Instruction <= '0;
            IF_Valid       <= 1'b0;
            ID_Flush       <= 1'b0;
        end else if (redirect) begin
            // Redirect wins in every state, including a repeated one in REDIRECT.
            pc             <= redirect_pc;
            hold_valid     <= 1'b0;
            IF_Valid       <= 1'b0;
            IF_Instruction <= '0;
            ID_Flush       <= 1'b1;
            state          <= REDIRECT;
        end else begin
            case (state)
                FETCH: begin
                    if (fetch) begin
                        pc <= seq_pc;
                        if (ID_Stall) begin
                            hold_pc    <= pc + PC_INC;
                            hold_instr <= Imem_Data;
                            hold_valid <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            IF_PC          <= pc + PC_INC;
                            IF_Instruction <= Imem_Data;
                            IF_Valid       <= 1'b1;
                        end
                    end else if (!ID_Stall) begin
                        IF_Valid       <= 1'b0;
                        IF_Instruction <= '0;
                    end
                end
                HOLD: begin
                    if (!ID_Stall && hold_valid) begin
                        IF_PC          <= hold_pc;
                        IF_Instruction <= hold_instr;
                        IF_Valid       <= 1'b1;
                        hold_valid     <= 1'b0;
                        state          <= FETCH;
                    end
                end
                default: begin
                    ID_Flush <= 1'b0;
                    state    <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench for if_fetch_unit with directed and random stimulus.
module tb_if_fetch_unit;

    localparam bit [31:0] RST_PC = 32'h8000_0000;
    localparam bit [31:0] X_VEC  = 32'h8000_0008;
    localparam bit [31:0] PAT    = 32'hA5A5_A5A5;
    localparam bit [31:0] SBIT   = 32'h8000_0000;

    logic        clk, reset, ID_Stall, Exception, Branch_Taken, Jump_Taken, Imem_Ready;
    logic [31:0] Branch_Target, Jump_Target, Imem_Data;
    logic        Imem_Req, IF_Valid, ID_Flush;
    logic [31:0] Imem_Addr, IF_PC, IF_Instruction;

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .ID_Stall       (ID_Stall),
        .Exception      (Exception),
        .Branch_Taken   (Branch_Taken),
        .Branch_Target  (Branch_Target),
        .Jump_Taken     (Jump_Taken),
        .Jump_Target    (Jump_Target),
        .Imem_Req       (Imem_Req),
        .Imem_Addr      (Imem_Addr),
        .Imem_Ready     (Imem_Ready),
        .Imem_Data      (Imem_Data),
        .IF_PC          (IF_PC),
        .IF_Instruction (IF_Instruction),
        .IF_Valid       (IF_Valid),
        .ID_Flush       (ID_Flush)
    );

    typedef struct packed {
        logic [31:0] ifpc;
        logic [31:0] ifin;
        logic [31:0] addr;
        logic        ifv;
        logic        flush;
        logic        req;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int tests = 0;
    int fails = 0;

    // Reference model: architectural pc, an optional parked word, and a flush flag.
    bit [31:0] m_pc, m_hpc, m_hin, m_ifpc, m_ifin;
    bit        m_held, m_flushing, m_ifv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("IF_PC", IF_PC, mon_e.ifpc);
            chk("IF_Instruction", IF_Instruction, mon_e.ifin);
            chk("Imem_Addr", Imem_Addr, mon_e.addr);
            chk("IF_Valid", 32'(IF_Valid), 32'(mon_e.ifv));
            chk("ID_Flush", 32'(ID_Flush), 32'(mon_e.flush));
            chk("Imem_Req", 32'(Imem_Req), 32'(mon_e.req));
        end
    end

    task automatic step(input bit r, input bit st, input bit ex, input bit br, input bit [31:0] bt,
                        input bit jp, input bit [31:0] jt, input bit rd);
        exp_t e;
        bit [31:0] sel;
        reset = r; ID_Stall = st; Exception = ex; Branch_Taken = br; Branch_Target = bt;
        Jump_Taken = jp; Jump_Target = jt; Imem_Ready = rd;
        Imem_Data = m_pc ^ PAT;
        if (r) begin
            m_pc = RST_PC; m_held = 0; m_flushing = 0; m_ifpc = 0; m_ifin = 0; m_ifv = 0;
        end else if (ex || br || jp) begin
            sel = br ? bt : jt;
            m_pc = ex ? X_VEC : ((sel & ~SBIT) | (sel & m_pc & SBIT));
            m_held = 0; m_ifv = 0; m_ifin = 0; m_flushing = 1;
        end else if (m_flushing) begin
            m_flushing = 0;
        end else if (m_held) begin
            if (!st) begin
                m_ifpc = m_hpc; m_ifin = m_hin; m_ifv = 1; m_held = 0;
            end
        end else if (rd) begin
            if (st) begin
                m_hpc = m_pc + 4; m_hin = m_pc ^ PAT; m_held = 1;
            end else begin
                m_ifpc = m_pc + 4; m_ifin = m_pc ^ PAT; m_ifv = 1;
            end
            m_pc = (m_pc & SBIT) | ((m_pc + 4) & ~SBIT);
        end else if (!st) begin
            m_ifv = 0; m_ifin = 0;
        end
        e.ifpc = m_ifpc; e.ifin = m_ifin; e.addr = m_pc; e.ifv = m_ifv;
        e.flush = m_flushing; e.req = !r && !m_held && !m_flushing;
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic run(input bit st, input bit rd, input int n);
        for (int i = 0; i < n; i++) step(0, st, 0, 0, 0, 0, 0, rd);
    endtask

    initial begin
        reset = 1; ID_Stall = 0; Exception = 0; Branch_Taken = 0; Jump_Taken = 0;
        Branch_Target = 0; Jump_Target = 0; Imem_Ready = 0; Imem_Data = 0;
        m_pc = RST_PC; m_held = 0; m_flushing = 0; m_ifpc = 0; m_ifin = 0; m_ifv = 0;
        m_hpc = 0; m_hin = 0;
        @(negedge clk);
        #1;
        // Reset for two cycles, then a straight sequential run.
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        run(0, 1, 4);
        // Stall three cycles around the fetch at 0x80000010, then release.
        run(1, 1, 3);
        run(0, 1, 3);
        // User-mode branch may not set the supervisor bit.
        step(0, 0, 0, 0, 0, 1, 32'h0000_0100, 1);
        run(0, 1, 1);
        step(0, 0, 0, 1, 32'h8000_0200, 0, 0, 1);
        run(0, 1, 3);
        // All three redirects together: exception wins.
        step(0, 0, 0, 0, 0, 1, 32'h0000_0040, 1);
        run(0, 1, 1);
        step(0, 0, 1, 1, 32'h0000_1234, 1, 32'h0000_5678, 1);
        run(0, 1, 3);
        // Memory wait abandoned by a jump arriving mid-wait.
        step(0, 0, 0, 0, 0, 1, 32'h8000_0020, 1);
        run(0, 1, 1);
        run(0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 32'h8000_0100, 0);
        run(0, 0, 2);
        run(0, 1, 3);
        // Increment wrap without touching the supervisor bit.
        step(0, 0, 0, 0, 0, 1, 32'h7FFF_FFFC, 1);
        run(0, 1, 3);
        // Back-to-back redirect while already flushing.
        step(0, 0, 0, 0, 0, 1, 32'h0000_0800, 1);
        step(0, 0, 0, 1, 32'h0000_0900, 0, 0, 1);
        run(0, 1, 2);
        // Reset while a word is parked in the hold buffer.
        run(1, 1, 2);
        step(1, 1, 0, 0, 0, 0, 0, 1);
        run(0, 1, 3);
        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 24) == 0, $urandom & ~32'h3,
                 $urandom_range(0, 24) == 0, $urandom & ~32'h3, $urandom_range(0, 9) < 7);
        end
        run(0, 1, 2);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
